// File: rtl/patch_stream_reorder.sv
// Raster pixel stream to patch-major element stream via a ping-pong strip buffer; first element
// of a strip is valid the cycle after its last pixel lands, pixel_ready drops while the write bank is still full.
module patch_stream_reorder #(
    parameter int IMAGE_SIZE = 8,
    parameter int PATCH_SIZE = 2,
    parameter int CHANNELS   = 1,
    parameter int PIXEL_W    = 8,
    localparam int NP        = IMAGE_SIZE / PATCH_SIZE,
    localparam int NPATCH    = NP * NP,
    localparam int DW        = CHANNELS * PIXEL_W,
    localparam int PIW       = (NPATCH > 1) ? $clog2(NPATCH) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [DW-1:0]  pixel_in,
    input  logic           pixel_valid,
    output logic           pixel_ready,
    output logic           ready,
    output logic [DW-1:0]  elem_out,
    output logic           elem_valid,
    input  logic           elem_ready,
    output logic           elem_last,
    output logic [PIW-1:0] patch_idx,
    output logic           frame_last,
    output logic           done
);
    localparam int CW = (IMAGE_SIZE > 1) ? $clog2(IMAGE_SIZE) : 1;
    localparam int RW = (PATCH_SIZE > 1) ? $clog2(PATCH_SIZE) : 1;
    localparam int SW = (NP > 1) ? $clog2(NP) : 1;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
    state_t state_q, state_d;

    logic [DW-1:0]  mem_q [2][PATCH_SIZE][IMAGE_SIZE];
    logic [1:0]     full_q, full_d;
    logic           wr_bank_q, rd_bank_q;
    logic [CW-1:0]  wr_col_q;
    logic [RW-1:0]  wr_row_q, rd_r_q, rd_c_q;
    logic [SW-1:0]  wr_strip_q, rd_strip_q, rd_pc_q;

    logic [DW-1:0]  elem_out_q;
    logic           elem_valid_q, elem_last_q, frame_last_q, out_rel_q, out_bank_q;
    logic [PIW-1:0] patch_idx_q;

    logic           accept, fill, frame_in_end, out_hs, rd_avail, load;
    logic           rd_patch_end, rd_bank_end;
    logic [CW-1:0]  rd_col;

    assign pixel_ready  = (state_q == IDLE && start) || (state_q == RUN && !full_q[wr_bank_q]);
    assign accept       = pixel_valid && pixel_ready;
    assign fill         = accept && (wr_col_q == CW'(IMAGE_SIZE-1)) && (wr_row_q == RW'(PATCH_SIZE-1));
    assign frame_in_end = fill && (wr_strip_q == SW'(NP-1));
    assign out_hs       = elem_valid_q && elem_ready;
    // A strip completing this cycle may be read immediately: its first element was written long ago.
    assign rd_avail     = full_q[rd_bank_q] || (fill && (wr_bank_q == rd_bank_q));
    assign load         = rd_avail && (!elem_valid_q || elem_ready);
    assign rd_patch_end = (rd_c_q == RW'(PATCH_SIZE-1)) && (rd_r_q == RW'(PATCH_SIZE-1));
    assign rd_bank_end  = rd_patch_end && (rd_pc_q == SW'(NP-1));
    assign rd_col       = CW'(rd_pc_q) * CW'(PATCH_SIZE) + CW'(rd_c_q);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (frame_in_end) state_d = FLUSH;
            FLUSH:   if (out_hs && frame_last_q) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Release and fill always target different banks, so both may land in one cycle.
    always_comb begin
        full_d = full_q;
        if (out_hs && out_rel_q) full_d[out_bank_q] = 1'b0;
        if (fill) full_d[wr_bank_q] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (accept) mem_q[wr_bank_q][wr_row_q][wr_col_q] <= pixel_in;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            full_q       <= '0;
            wr_bank_q    <= 1'b0;
            rd_bank_q    <= 1'b0;
            wr_col_q     <= '0;
            wr_row_q     <= '0;
            wr_strip_q   <= '0;
            rd_r_q       <= '0;
            rd_c_q       <= '0;
            rd_pc_q      <= '0;
            rd_strip_q   <= '0;
            elem_out_q   <= '0;
            elem_valid_q <= 1'b0;
            elem_last_q  <= 1'b0;
            frame_last_q <= 1'b0;
            patch_idx_q  <= '0;
            out_rel_q    <= 1'b0;
            out_bank_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            full_q  <= full_d;
            if (accept) begin
                if (wr_col_q == CW'(IMAGE_SIZE-1)) begin
                    wr_col_q <= '0;
                    if (wr_row_q == RW'(PATCH_SIZE-1)) begin
                        wr_row_q   <= '0;
                        wr_bank_q  <= ~wr_bank_q;
                        wr_strip_q <= (wr_strip_q == SW'(NP-1)) ? '0 : wr_strip_q + 1'b1;
                    end else begin
                        wr_row_q <= wr_row_q + 1'b1;
                    end
                end else begin
                    wr_col_q <= wr_col_q + 1'b1;
                end
            end
            if (load) begin
                elem_out_q   <= mem_q[rd_bank_q][rd_r_q][rd_col];
                elem_valid_q <= 1'b1;
                elem_last_q  <= rd_patch_end;
                frame_last_q <= rd_bank_end && (rd_strip_q == SW'(NP-1));
                patch_idx_q  <= PIW'(rd_strip_q) * PIW'(NP) + PIW'(rd_pc_q);
                out_rel_q    <= rd_bank_end;
                out_bank_q   <= rd_bank_q;
                rd_c_q       <= (rd_c_q == RW'(PATCH_SIZE-1)) ? '0 : rd_c_q + 1'b1;
                if (rd_c_q == RW'(PATCH_SIZE-1)) begin
                    rd_r_q <= (rd_r_q == RW'(PATCH_SIZE-1)) ? '0 : rd_r_q + 1'b1;
                    if (rd_bank_end) begin
                        rd_pc_q    <= '0;
                        rd_bank_q  <= ~rd_bank_q;
                        rd_strip_q <= (rd_strip_q == SW'(NP-1)) ? '0 : rd_strip_q + 1'b1;
                    end else if (rd_patch_end) begin
                        rd_pc_q <= rd_pc_q + 1'b1;
                    end
                end
            end else if (out_hs) begin
                elem_valid_q <= 1'b0;
                elem_last_q  <= 1'b0;
                frame_last_q <= 1'b0;
            end
            // Bank pointers restart at 0 each frame even when the strip count is odd.
            if (state_q == DONE) begin
                wr_bank_q <= 1'b0;
                rd_bank_q <= 1'b0;
            end
        end
    end

    assign ready      = (state_q == IDLE);
    assign done       = (state_q == DONE);
    assign elem_out   = elem_out_q;
    assign elem_valid = elem_valid_q;
    assign elem_last  = elem_last_q;
    assign frame_last = frame_last_q;
    assign patch_idx  = patch_idx_q;
endmodule
